lp805x_exit_mon: RTL and testbench

Synthesizable exit-code monitor that sits directly downstream of the lp805x core's port-0 output. It qualifies values written to P0 by the self-checking test programs, decides pass / fail / timeout, and reports the exit code and the clock-cycle count from reset release to the verdict. It lets the instruction and XRAM regression programs run on FPGA, where no simulator `$display` or `$finish` exists.

---
 rtl/lp805x_exit_mon_if.sv | 23 ++
 rtl/lp805x_exit_mon.sv | 102 ++++++++++
 tb/tb_lp805x_exit_mon.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lp805x_exit_mon_if.sv
// Port-0 observation and verdict signals between the lp805x core side and the exit monitor.
// Latency: none, wiring only; no backpressure because P0 is a level that is sampled every cycle.
interface lp805x_exit_mon_if #(
    parameter int CNT_W = 32
);
    logic [7:0]       p0_i;
    logic             clear_i;
    logic             done_o;
    logic             pass_o;
    logic             timeout_o;
    logic [7:0]       code_o;
    logic [CNT_W-1:0] cycles_o;

    modport master (
        output p0_i, clear_i,
        input  done_o, pass_o, timeout_o, code_o, cycles_o
    );

    modport slave (
        input  p0_i, clear_i,
        output done_o, pass_o, timeout_o, code_o, cycles_o
    );
endinterface

// File: rtl/lp805x_exit_mon.sv
// Qualifies P0 exit codes from self-checking programs into a sticky pass/fail/timeout verdict plus a cycle count.
// Latency: verdict STABLE+1 edges after a P0 change; no backpressure, P0 is sampled every cycle.
module lp805x_exit_mon #(
    parameter logic [7:0] PASS_CODE   = 8'h7F,
    parameter logic [7:0] IDLE_CODE   = 8'hFF,
    parameter int         STABLE      = 2,
    parameter int         CNT_W       = 32,
    parameter int         TIMEOUT_CYC = 0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    lp805x_exit_mon_if.slave  mon
);
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_PASS = 2'd1;
    localparam logic [1:0] S_FAIL = 2'd2;
    localparam logic [1:0] S_TOUT = 2'd3;

    localparam logic [3:0]       STAB_MAX  = 4'(STABLE);
    localparam logic [CNT_W-1:0] CYC_MAX   = '1;
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam bit               TOUT_EN   = (TIMEOUT_CYC != 0);

    logic [1:0]       state;
    logic [7:0]       p0_q;
    logic [7:0]       cand;
    logic [3:0]       stab;
    logic [CNT_W-1:0] cycles;
    logic             done;
    logic             pass;
    logic             tout;
    logic [7:0]       code;

    logic [7:0] cand_nx;
    logic [3:0] stab_nx;
    logic       accept;
    logic       tout_hit;

    // Acceptance looks at the tracker value being written this edge, so a stable
    // value is declared on the same edge its count reaches STABLE.
    always_comb begin
        cand_nx = p0_q;
        stab_nx = 4'd1;
        if (p0_q == cand) begin
            cand_nx = cand;
            stab_nx = (stab == STAB_MAX) ? stab : stab + 4'd1;
        end
    end

    assign accept   = (state == S_RUN) && (cand_nx != IDLE_CODE) && (stab_nx == STAB_MAX);
    assign tout_hit = TOUT_EN && (state == S_RUN) && (cycles == TOUT_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= S_RUN;
            p0_q   <= IDLE_CODE;
            cand   <= IDLE_CODE;
            stab   <= 4'd0;
            cycles <= '0;
            done   <= 1'b0;
            pass   <= 1'b0;
            tout   <= 1'b0;
            code   <= 8'h00;
        end else begin
            p0_q <= mon.p0_i;
            if (mon.clear_i) begin
                state  <= S_RUN;
                cand   <= IDLE_CODE;
                stab   <= 4'd0;
                cycles <= '0;
                done   <= 1'b0;
                pass   <= 1'b0;
                tout   <= 1'b0;
                code   <= 8'h00;
            end else if (state == S_RUN) begin
                cand <= cand_nx;
                stab <= stab_nx;
                if (cycles != CYC_MAX) begin
                    cycles <= cycles + 1'b1;
                end
                if (accept) begin
                    state <= (cand_nx == PASS_CODE) ? S_PASS : S_FAIL;
                    code  <= cand_nx;
                    done  <= 1'b1;
                    pass  <= (cand_nx == PASS_CODE);
                end else if (tout_hit) begin
                    state <= S_TOUT;
                    code  <= p0_q;
                    done  <= 1'b1;
                    tout  <= 1'b1;
                    pass  <= 1'b0;
                end
            end
        end
    end

    assign mon.done_o    = done;
    assign mon.pass_o    = pass;
    assign mon.timeout_o = tout;
    assign mon.code_o    = code;
    assign mon.cycles_o  = cycles;
endmodule

// File: tb/tb_lp805x_exit_mon.sv
// Bench for lp805x_exit_mon: default, timeout-enabled and 8-bit-counter instances, verdicts checked from a queue.
module tb_lp805x_exit_mon;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    lp805x_exit_mon_if #(.CNT_W(32)) if0 ();
    lp805x_exit_mon_if #(.CNT_W(32)) if1 ();
    lp805x_exit_mon_if #(.CNT_W(8))  if2 ();

    lp805x_exit_mon u_dut0 (.wb_clk_i(clk), .wb_rst_i(rst0), .mon(if0.slave));
    lp805x_exit_mon #(.TIMEOUT_CYC(50)) u_dut1 (.wb_clk_i(clk), .wb_rst_i(rst1), .mon(if1.slave));
    lp805x_exit_mon #(.CNT_W(8)) u_dut2 (.wb_clk_i(clk), .wb_rst_i(rst2), .mon(if2.slave));

    typedef struct {
        string       tag;
        logic        done;
        logic        pass;
        logic        tout;
        logic [7:0]  code;
        logic [31:0] cyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input int d, output logic dn, output logic ps, output logic to,
                      output logic [7:0] cd, output logic [31:0] cy);
        case (d)
            0: begin dn = if0.done_o; ps = if0.pass_o; to = if0.timeout_o; cd = if0.code_o; cy = if0.cycles_o; end
            1: begin dn = if1.done_o; ps = if1.pass_o; to = if1.timeout_o; cd = if1.code_o; cy = if1.cycles_o; end
            default: begin
                dn = if2.done_o; ps = if2.pass_o; to = if2.timeout_o; cd = if2.code_o; cy = {24'd0, if2.cycles_o};
            end
        endcase
    endtask

    task automatic set_p0(input int d, input logic [7:0] v);
        case (d)
            0: if0.p0_i = v;
            1: if1.p0_i = v;
            default: if2.p0_i = v;
        endcase
    endtask

    task automatic set_rst(input int d, input logic v);
        case (d)
            0: rst0 = v;
            1: rst1 = v;
            default: rst2 = v;
        endcase
    endtask

    task automatic hold(input int d, input logic [7:0] v, input int n);
        set_p0(d, v);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input int d, input string tag);
        logic dn, ps, to;
        logic [7:0] cd;
        logic [31:0] cy;
        rd(d, dn, ps, to, cd, cy);
        check({tag, "_done"}, dn, 0);
        check({tag, "_pass"}, ps, 0);
        check({tag, "_tout"}, to, 0);
        check({tag, "_code"}, cd, 0);
        check({tag, "_cyc"}, cy, 0);
    endtask

    // Reset asserted at a falling edge, released at a falling edge: the next rising edge is cycle 1.
    task automatic do_reset(input int d, input string tag);
        @(negedge clk);
        set_p0(d, 8'hFF);
        set_rst(d, 1'b1);
        repeat (2) @(negedge clk);
        check_idle(d, tag);
        set_rst(d, 1'b0);
    endtask

    task automatic push(input string tag, input logic dn, input logic ps, input logic to,
                        input logic [7:0] cd, input logic [31:0] cy, input int lat);
        exp_t e;
        e.tag = tag; e.done = dn; e.pass = ps; e.tout = to; e.code = cd; e.cyc = cy; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic collect(input int d, input int budget);
        exp_t e;
        logic dn, ps, to;
        logic [7:0] cd;
        logic [31:0] cy;
        int k;
        k = 0;
        dn = 1'b0;
        while (!dn && k < budget) begin
            @(negedge clk);
            k++;
            rd(d, dn, ps, to, cd, cy);
        end
        e = exp_q.pop_front();
        check({e.tag, "_done"}, dn, e.done);
        check({e.tag, "_lat"}, k, e.lat);
        check({e.tag, "_pass"}, ps, e.pass);
        check({e.tag, "_tout"}, to, e.tout);
        check({e.tag, "_code"}, cd, e.code);
        check({e.tag, "_cyc"}, cy, e.cyc);
    endtask

    task automatic pulse_clear0();
        if0.clear_i = 1'b1;
        @(negedge clk);
        if0.clear_i = 1'b0;
    endtask

    initial begin
        logic dn, ps, to;
        logic [7:0] cd;
        logic [31:0] cy;

        if0.p0_i = 8'hFF; if0.clear_i = 1'b0;
        if1.p0_i = 8'hFF; if1.clear_i = 1'b0;
        if2.p0_i = 8'hFF; if2.clear_i = 1'b0;

        // Pass after a long idle stretch
        do_reset(0, "rst0");
        hold(0, 8'hFF, 100);
        push("pass103", 1, 1, 0, 8'h7F, 103, 3);
        set_p0(0, 8'h7F);
        collect(0, 10);

        // Failure code, then later P0 activity must not disturb the verdict
        do_reset(0, "rst0b");
        hold(0, 8'hFF, 5);
        push("fail03", 1, 0, 0, 8'h03, 8, 3);
        set_p0(0, 8'h03);
        collect(0, 10);
        hold(0, 8'h7F, 10);
        rd(0, dn, ps, to, cd, cy);
        check("sticky_pass", ps, 0);
        check("sticky_code", cd, 8'h03);
        check("sticky_cyc", cy, 8);

        // Clear after FAIL restarts counting from the clear edge
        hold(0, 8'hFF, 3);
        pulse_clear0();
        check_idle(0, "clr");
        hold(0, 8'hFF, 10);
        push("clr_pass", 1, 1, 0, 8'h7F, 13, 3);
        set_p0(0, 8'h7F);
        collect(0, 10);

        // Short-lived values are discarded
        do_reset(0, "rst0c");
        hold(0, 8'hFF, 10);
        hold(0, 8'h7F, 1);
        hold(0, 8'h55, 1);
        hold(0, 8'hFF, 20);
        rd(0, dn, ps, to, cd, cy);
        check("glitch_done", dn, 0);
        check("glitch_code", cd, 0);
        check("glitch_cyc", cy, 32);

        // Asynchronous reset mid-run
        do_reset(0, "rst0d");
        hold(0, 8'hFF, 5);
        hold(0, 8'h03, 1);
        rst0 = 1'b1;
        #1;
        check_idle(0, "async");
        @(negedge clk);
        set_p0(0, 8'hFF);
        rst0 = 1'b0;
        hold(0, 8'hFF, 7);
        push("after_rst", 1, 1, 0, 8'h7F, 10, 3);
        set_p0(0, 8'h7F);
        collect(0, 10);

        // Timeout with P0 idle, then frozen counter
        do_reset(1, "rst1");
        push("tout50", 1, 0, 1, 8'hFF, 50, 50);
        collect(1, 70);
        hold(1, 8'h7F, 10);
        rd(1, dn, ps, to, cd, cy);
        check("tout_frozen_cyc", cy, 50);
        check("tout_frozen_pass", ps, 0);

        // Acceptance on the timeout edge wins
        do_reset(1, "rst1b");
        hold(1, 8'hFF, 47);
        push("tie_pass", 1, 1, 0, 8'h7F, 50, 3);
        set_p0(1, 8'h7F);
        collect(1, 10);

        // One edge too late: timeout reports the sampled P0 value
        do_reset(1, "rst1c");
        hold(1, 8'hFF, 48);
        push("late_tout", 1, 0, 1, 8'h7F, 50, 2);
        set_p0(1, 8'h7F);
        collect(1, 10);

        // 8-bit counter saturates
        do_reset(2, "rst2");
        hold(2, 8'hFF, 300);
        rd(2, dn, ps, to, cd, cy);
        check("sat_done", dn, 0);
        check("sat_cyc", cy, 8'hFF);
        push("sat_pass", 1, 1, 0, 8'h7F, 8'hFF, 3);
        set_p0(2, 8'h7F);
        collect(2, 10);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
